// File: rtl/ntt_pkg.sv
// Shared definitions for the NTT butterfly PE: default modulus, mode encoding
// and the modular add/sub/halve helpers used by the datapath.
package ntt_pkg;

    localparam int Q_DEFAULT = 12289;

    typedef enum logic [1:0] {
        MODE_NTT  = 2'b00,
        MODE_INTT = 2'b01,
        MODE_PWM  = 2'b10,
        MODE_RSVD = 2'b11
    } mode_e;

    function automatic logic [31:0] mod_add(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] q);
        logic [31:0] s;
        s = a + b;
        return (s >= q) ? s - q : s;
    endfunction

    function automatic logic [31:0] mod_sub(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] q);
        return (a < b) ? a - b + q : a - b;
    endfunction

    // Division by two in the field: odd values borrow one modulus to become even.
    function automatic logic [31:0] mod_half(input logic [31:0] x, input logic [31:0] q);
        return x[0] ? (x + q) >> 1 : x >> 1;
    endfunction

endpackage

// File: rtl/mod_mul_pipe.sv
// Pipelined modular multiplier: p = a*b mod Q after exactly MUL_LAT clocks,
// with a valid bit travelling alongside the data.
module mod_mul_pipe #(
    parameter int DATA_WIDTH = 14,
    parameter int Q          = 12289,
    parameter int MUL_LAT    = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    input  logic                  i_in_valid,
    output logic [DATA_WIDTH-1:0] o_p,
    output logic                  o_out_valid
);

    localparam int PW = 2 * DATA_WIDTH;
    localparam logic [PW-1:0] QP = PW'(Q);

    logic [PW-1:0]         w_prod;
    logic [DATA_WIDTH-1:0] r_p;
    logic [MUL_LAT-1:0]    r_vld;

    assign w_prod = PW'(i_a) * PW'(i_b);

    // Raw product is carried through the early stages; reduction happens in the last one.
    generate
        if (MUL_LAT == 1) begin : g_single
            always_ff @(posedge i_clk) begin
                r_p <= DATA_WIDTH'(w_prod % QP);
            end
        end else begin : g_multi
            logic [PW-1:0] r_prod [MUL_LAT-1];
            always_ff @(posedge i_clk) begin
                r_prod[0] <= w_prod;
                for (int i = 1; i < MUL_LAT - 1; i++) begin
                    r_prod[i] <= r_prod[i-1];
                end
                r_p <= DATA_WIDTH'(r_prod[MUL_LAT-2] % QP);
            end
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vld <= '0;
        end else begin
            r_vld[0] <= i_in_valid;
            for (int i = 1; i < MUL_LAT; i++) begin
                r_vld[i] <= r_vld[i-1];
            end
        end
    end

    assign o_p         = r_p;
    assign o_out_valid = r_vld[MUL_LAT-1];

endmodule

// File: rtl/ntt_bf_pe_stream.sv
// Unified CT-NTT / GS-INTT / pointwise-multiply butterfly PE with a fixed
// MUL_LAT+3 cycle latency in every mode and drain-before-switch mode changes.
module ntt_bf_pe_stream
    import ntt_pkg::*;
#(
    parameter int DATA_WIDTH = 14,
    parameter int Q          = Q_DEFAULT,
    parameter int MUL_LAT    = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    input  logic [1:0]            i_in_mode,
    input  logic [DATA_WIDTH-1:0] i_u,
    input  logic [DATA_WIDTH-1:0] i_v,
    input  logic [DATA_WIDTH-1:0] i_w,
    output logic                  o_out_valid,
    output logic [DATA_WIDTH-1:0] o_bf_upper,
    output logic [DATA_WIDTH-1:0] o_bf_lower,
    output logic                  o_busy
);

    localparam int LAT = MUL_LAT + 3;
    localparam int CW  = $clog2(LAT + 1);
    localparam logic [31:0] QW = 32'(Q);

    logic [CW-1:0]         r_count;
    logic [1:0]            r_cur_mode;
    logic                  w_accept;

    logic                  r_s1_vld;
    mode_e                 r_s1_mode;
    logic [DATA_WIDTH-1:0] r_s1_u, r_s1_v, r_s1_w;

    logic [DATA_WIDTH-1:0] w_s2_diff, w_s2_half;
    logic                  r_s2_vld;
    mode_e                 r_s2_mode;
    logic [DATA_WIDTH-1:0] r_s2_a, r_s2_b, r_s2_side;

    logic [DATA_WIDTH-1:0] w_mul_p;
    logic                  w_mul_vld;
    logic [DATA_WIDTH-1:0] r_side_dly [MUL_LAT];
    mode_e                 r_mode_dly [MUL_LAT];

    logic [DATA_WIDTH-1:0] w_up, w_lo;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_bf_upper, r_bf_lower;

    // A beat of a different mode waits until every older beat has been emitted.
    assign o_busy     = (r_count != '0);
    assign o_in_ready = ~(i_in_valid & (i_in_mode != r_cur_mode) & o_busy);
    assign w_accept   = i_in_valid & o_in_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count    <= '0;
            r_cur_mode <= MODE_NTT;
        end else begin
            if (w_accept && !r_out_valid) begin
                r_count <= r_count + 1'b1;
            end else if (!w_accept && r_out_valid) begin
                r_count <= r_count - 1'b1;
            end
            if (w_accept) begin
                r_cur_mode <= i_in_mode;
            end
        end
    end

    // The reserved encoding is folded into PWM before it enters the datapath.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1_vld <= 1'b0;
        end else begin
            r_s1_vld <= w_accept;
        end
        r_s1_mode <= (i_in_mode == MODE_RSVD) ? MODE_PWM : mode_e'(i_in_mode);
        r_s1_u    <= i_u;
        r_s1_v    <= i_v;
        r_s1_w    <= i_w;
    end

    assign w_s2_diff = DATA_WIDTH'(mod_sub(32'(r_s1_u), 32'(r_s1_v), QW));
    assign w_s2_half = DATA_WIDTH'(mod_half(mod_add(32'(r_s1_u), 32'(r_s1_v), QW), QW));

    // INTT multiplies the difference and carries the halved sum; other modes carry u.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s2_vld <= 1'b0;
        end else begin
            r_s2_vld <= r_s1_vld;
        end
        r_s2_mode <= r_s1_mode;
        r_s2_b    <= r_s1_w;
        if (r_s1_mode == MODE_INTT) begin
            r_s2_a    <= w_s2_diff;
            r_s2_side <= w_s2_half;
        end else begin
            r_s2_a    <= r_s1_v;
            r_s2_side <= r_s1_u;
        end
    end

    mod_mul_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .Q          (Q),
        .MUL_LAT    (MUL_LAT)
    ) u_mul (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_a         (r_s2_a),
        .i_b         (r_s2_b),
        .i_in_valid  (r_s2_vld),
        .o_p         (w_mul_p),
        .o_out_valid (w_mul_vld)
    );

    always_ff @(posedge i_clk) begin
        r_side_dly[0] <= r_s2_side;
        r_mode_dly[0] <= r_s2_mode;
        for (int i = 1; i < MUL_LAT; i++) begin
            r_side_dly[i] <= r_side_dly[i-1];
            r_mode_dly[i] <= r_mode_dly[i-1];
        end
    end

    always_comb begin
        w_up = w_mul_p;
        w_lo = r_side_dly[MUL_LAT-1];
        case (r_mode_dly[MUL_LAT-1])
            MODE_NTT: begin
                w_up = DATA_WIDTH'(mod_add(32'(r_side_dly[MUL_LAT-1]), 32'(w_mul_p), QW));
                w_lo = DATA_WIDTH'(mod_sub(32'(r_side_dly[MUL_LAT-1]), 32'(w_mul_p), QW));
            end
            MODE_INTT: begin
                w_up = r_side_dly[MUL_LAT-1];
                w_lo = DATA_WIDTH'(mod_half(32'(w_mul_p), QW));
            end
            default: begin
            end
        endcase
    end

    // Result registers hold their last value across bubbles.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_out_valid <= 1'b0;
            r_bf_upper  <= '0;
            r_bf_lower  <= '0;
        end else begin
            r_out_valid <= w_mul_vld;
            if (w_mul_vld) begin
                r_bf_upper <= w_up;
                r_bf_lower <= w_lo;
            end
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_bf_upper  = r_bf_upper;
    assign o_bf_lower  = r_bf_lower;

endmodule

// File: tb/tb_ntt_bf_pe_stream.sv
// Self-checking bench for ntt_bf_pe_stream: directed vectors plus random
// streams scored against a plain-arithmetic modular reference model.
module tb_ntt_bf_pe_stream;

    localparam int DW   = 14;
    localparam int Q    = 12289;
    localparam int ML   = 4;
    localparam int LAT  = ML + 3;
    localparam int INV2 = (Q + 1) / 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          inValid = 1'b0;
    logic [1:0]    inMode = 2'b00;
    logic [DW-1:0] u = '0, v = '0, w = '0;
    logic          inReady, outValid, busy;
    logic [DW-1:0] bfUpper, bfLower;

    ntt_bf_pe_stream #(.DATA_WIDTH(DW), .Q(Q), .MUL_LAT(ML)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_in_valid  (inValid),
        .o_in_ready  (inReady),
        .i_in_mode   (inMode),
        .i_u         (u),
        .i_v         (v),
        .i_w         (w),
        .o_out_valid (outValid),
        .o_bf_upper  (bfUpper),
        .o_bf_lower  (bfLower),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int up;
        int lo;
        int due;
    } beat_t;

    beat_t sb[$];
    int    errors = 0, checks = 0, edgeNo = 0, curModeM = 0;
    int    runLen = 0, maxRun = 0, lastUp = 0, lastLo = 0;
    bit    shownNow = 1'b0;

    function automatic int modq(input longint x);
        longint r;
        r = x % Q;
        if (r < 0) r += Q;
        return int'(r);
    endfunction

    function automatic beat_t model(input int mode, input int a, input int b, input int c);
        beat_t res;
        longint t;
        res.due = 0;
        if (mode == 0) begin
            t = longint'(b) * c;
            res.up = modq(a + t);
            res.lo = modq(a - t);
        end else if (mode == 1) begin
            res.up = modq(longint'(a + b) * INV2);
            res.lo = modq(longint'(a - b) * c % Q * INV2);
        end else begin
            res.up = modq(longint'(b) * c);
            res.lo = a;
        end
        return res;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic checkCycle();
        bit expV;
        expV = (sb.size() > 0) && (sb[0].due == edgeNo);
        checkOutput("out_valid", outValid, expV);
        if (outValid) begin
            lastUp = bfUpper;
            lastLo = bfLower;
            runLen++;
            if (runLen > maxRun) maxRun = runLen;
        end else begin
            runLen = 0;
        end
        if (expV) begin
            checkOutput("bf_upper", bfUpper, sb[0].up);
            checkOutput("bf_lower", bfLower, sb[0].lo);
            void'(sb.pop_front());
        end
        shownNow = expV;
        checkOutput("busy", busy, (sb.size() != 0) || expV);
    endtask

    task automatic applyStimulus(input bit valid, input int mode, input int a, input int b,
                                 input int c, output bit accepted);
        bit    expReady;
        beat_t bt;
        inValid = valid;
        inMode  = 2'(mode);
        u = DW'(a);
        v = DW'(b);
        w = DW'(c);
        #1;
        expReady = !(valid && (mode != curModeM) && ((sb.size() != 0) || shownNow));
        checkOutput("in_ready", inReady, expReady);
        accepted = valid && expReady;
        if (accepted) begin
            bt = model(mode, a, b, c);
            bt.due = edgeNo + LAT;
            sb.push_back(bt);
            curModeM = mode;
        end
        @(posedge clk);
        edgeNo++;
        @(negedge clk);
        checkCycle();
    endtask

    task automatic sendBeat(input int mode, input int a, input int b, input int c);
        bit acc;
        acc = 1'b0;
        for (int i = 0; i < 40 && !acc; i++) begin
            applyStimulus(1'b1, mode, a, b, c, acc);
        end
        checkOutput("send_accepted", acc, 1);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, curModeM, 0, 0, 0, acc);
        end
    endtask

    task automatic doReset(input int n);
        rst     = 1'b1;
        inValid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            edgeNo++;
        end
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        curModeM = 0;
        shownNow = 1'b0;
        runLen   = 0;
        #1;
        checkOutput("reset_out_valid", outValid, 0);
        checkOutput("reset_upper", bfUpper, 0);
        checkOutput("reset_lower", bfLower, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_in_ready", inReady, 1);
    endtask

    initial begin
        bit havePend, acc;
        int pMode, pU, pV, pW, lastDue;

        // Reset state
        doReset(2);

        // Directed NTT / INTT / PWM vectors
        sendBeat(0, 5, 3, 2);
        idle(LAT);
        checkOutput("ntt_upper", lastUp, 11);
        checkOutput("ntt_lower", lastLo, 12288);
        sendBeat(1, 5, 3, 2);
        idle(LAT);
        checkOutput("intt_upper", lastUp, 4);
        checkOutput("intt_lower", lastLo, 2);
        sendBeat(1, 1, 0, 1);
        idle(LAT);
        checkOutput("intt_half_upper", lastUp, 6145);
        checkOutput("intt_half_lower", lastLo, 6145);
        sendBeat(2, 77, 12288, 12288);
        idle(LAT);
        checkOutput("pwm_upper", lastUp, 1);
        checkOutput("pwm_lower", lastLo, 77);

        // 100 back-to-back random PWM beats
        maxRun = 0;
        for (int i = 0; i < 100; i++) begin
            sendBeat(2, $urandom_range(0, Q - 1), $urandom_range(0, Q - 1),
                     $urandom_range(0, Q - 1));
        end
        idle(LAT + 2);
        checkOutput("pwm_run_length", maxRun, 100);

        // Mode switch: three NTT beats, then an INTT beat held until accepted
        for (int i = 0; i < 3; i++) begin
            sendBeat(0, $urandom_range(0, Q - 1), $urandom_range(0, Q - 1),
                     $urandom_range(0, Q - 1));
        end
        lastDue = sb[sb.size() - 1].due;
        sendBeat(1, $urandom_range(0, Q - 1), $urandom_range(0, Q - 1),
                 $urandom_range(0, Q - 1));
        checkOutput("switch_accept_edge", edgeNo, lastDue + 2);
        idle(LAT + 2);

        // Reset in the middle of traffic
        sendBeat(0, 100, 200, 300);
        sendBeat(0, 400, 500, 600);
        idle(3);
        doReset(1);
        idle(LAT + 4);

        // Boundary operands in every mode
        sendBeat(0, 0, 12288, 12288);
        idle(LAT);
        checkOutput("bnd_ntt_upper", lastUp, 1);
        checkOutput("bnd_ntt_lower", lastLo, 12288);
        sendBeat(1, 0, 12288, 12288);
        idle(LAT);
        checkOutput("bnd_intt_upper", lastUp, 6144);
        checkOutput("bnd_intt_lower", lastLo, 6144);
        sendBeat(2, 0, 12288, 12288);
        idle(LAT);
        checkOutput("bnd_pwm_upper", lastUp, 1);
        checkOutput("bnd_pwm_lower", lastLo, 0);

        // Random bubbles and occasional mode changes against the scoreboard
        havePend = 1'b0;
        pMode = 0; pU = 0; pV = 0; pW = 0;
        for (int i = 0; i < 400; i++) begin
            if (!havePend && ($urandom_range(0, 2) != 0)) begin
                havePend = 1'b1;
                if ($urandom_range(0, 9) == 0) pMode = $urandom_range(0, 3);
                pU = $urandom_range(0, Q - 1);
                pV = $urandom_range(0, Q - 1);
                pW = $urandom_range(0, Q - 1);
            end
            applyStimulus(havePend, pMode, pU, pV, pW, acc);
            if (acc) havePend = 1'b0;
        end
        idle(LAT + 2);
        checkOutput("drain_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
